// File: rtl/native_vtg.sv
// Video timing generator for the native video path.
// Advances one pixel per ce strobe; parks at the last raster position on
// reset, disable or resync so the next ce yields a clean start-of-frame.
module native_vtg #(
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned H_FP     = 88,
  parameter int unsigned H_SYNC   = 44,
  parameter int unsigned H_BP     = 148,
  parameter int unsigned V_ACTIVE = 1080,
  parameter int unsigned V_FP     = 4,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 36,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1,
  parameter int unsigned HCNT_W   = 12,
  parameter int unsigned VCNT_W   = 11
) (
  input  logic              natv_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              ce,
  input  logic              resync,
  output logic              hsync,
  output logic              vsync,
  output logic              hblank,
  output logic              vblank,
  output logic              active,
  output logic              fid,
  output logic [HCNT_W-1:0] ppl,
  output logic [VCNT_W-1:0] lpf,
  output logic [HCNT_W-1:0] hcnt,
  output logic [VCNT_W-1:0] vcnt,
  output logic              sof
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [HCNT_W-1:0] H_LAST = HCNT_W'(H_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_LAST = VCNT_W'(V_TOTAL - 1);

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic              hsync_q, hsync_d;
  logic              vsync_q, vsync_d;
  logic              hblank_q, hblank_d;
  logic              vblank_q, vblank_d;
  logic              active_q, active_d;
  logic              sof_q, sof_d;
  logic              park_c;
  logic              hsync_on_c;
  logic              vsync_on_c;

  // Any of these abandons the current raster and returns to park.
  assign park_c = rst || !enable || resync;

  // Next position and its decode; outputs are decoded from the next count
  // so the timing flags line up with hcnt/vcnt on the same edge.
  always_comb begin
    hcnt_d     = hcnt_q;
    vcnt_d     = vcnt_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    hblank_d   = hblank_q;
    vblank_d   = vblank_q;
    active_d   = active_q;
    sof_d      = 1'b0;
    hsync_on_c = 1'b0;
    vsync_on_c = 1'b0;

    if (park_c) begin
      hcnt_d   = H_LAST;
      vcnt_d   = V_LAST;
      hsync_d  = !HS_POL;
      vsync_d  = !VS_POL;
      hblank_d = 1'b1;
      vblank_d = 1'b1;
      active_d = 1'b0;
    end else if (ce) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VCNT_W'(1);
      end else begin
        hcnt_d = hcnt_q + HCNT_W'(1);
      end
      hsync_on_c = (32'(hcnt_d) >= H_SYNC_BEG) && (32'(hcnt_d) < H_SYNC_END);
      vsync_on_c = (32'(vcnt_d) >= V_SYNC_BEG) && (32'(vcnt_d) < V_SYNC_END);
      hblank_d   = 32'(hcnt_d) >= H_ACTIVE;
      vblank_d   = 32'(vcnt_d) >= V_ACTIVE;
      active_d   = !hblank_d && !vblank_d;
      hsync_d    = hsync_on_c ? HS_POL : !HS_POL;
      vsync_d    = vsync_on_c ? VS_POL : !VS_POL;
      sof_d      = (hcnt_d == '0) && (vcnt_d == '0);
    end
  end

  // Counter and timing output registers.
  always_ff @(posedge natv_clk) begin
    hcnt_q   <= hcnt_d;
    vcnt_q   <= vcnt_d;
    hsync_q  <= hsync_d;
    vsync_q  <= vsync_d;
    hblank_q <= hblank_d;
    vblank_q <= vblank_d;
    active_q <= active_d;
    sof_q    <= sof_d;
  end

  assign hcnt   = hcnt_q;
  assign vcnt   = vcnt_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign hblank = hblank_q;
  assign vblank = vblank_q;
  assign active = active_q;
  assign sof    = sof_q;
  assign fid    = 1'b0;
  assign ppl    = HCNT_W'(H_ACTIVE);
  assign lpf    = VCNT_W'(V_ACTIVE);

endmodule

// File: tb/tb_native_vtg.sv
// Self-checking bench for native_vtg on a 16x8 raster, with a second
// instance using inverted sync polarity.
module tb_native_vtg;

  localparam int H_TOT = 16;
  localparam int V_TOT = 8;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int LAST_POS = FRAME - 1;

  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b0, ce = 1'b0, resync = 1'b0;

  logic       hsync, vsync, hblank, vblank, active, fid, sof;
  logic [3:0] ppl, hcnt;
  logic [2:0] lpf, vcnt;
  logic       hsync_n, vsync_n, hblank_n, vblank_n, active_n, fid_n, sof_n;
  logic [3:0] ppl_n, hcnt_n;
  logic [2:0] lpf_n, vcnt_n;

  int checks = 0;
  int failures = 0;

  // Model: linear raster position; sof expected when an advance lands on 0.
  int   pos = LAST_POS;
  logic esof = 1'b0;
  logic [14:0] exp_w;
  wire  [14:0] act_w = {hcnt, vcnt, hsync, vsync, hblank, vblank, active, sof,
                        hsync_n, vsync_n};

  always #5 clk = ~clk;

  native_vtg #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .HCNT_W(4), .VCNT_W(3)
  ) dut (
    .natv_clk(clk), .rst(rst), .enable(enable), .ce(ce), .resync(resync),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank),
    .active(active), .fid(fid), .ppl(ppl), .lpf(lpf), .hcnt(hcnt),
    .vcnt(vcnt), .sof(sof)
  );

  native_vtg #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .HCNT_W(4), .VCNT_W(3)
  ) dut_inv (
    .natv_clk(clk), .rst(rst), .enable(enable), .ce(ce), .resync(resync),
    .hsync(hsync_n), .vsync(vsync_n), .hblank(hblank_n), .vblank(vblank_n),
    .active(active_n), .fid(fid_n), .ppl(ppl_n), .lpf(lpf_n), .hcnt(hcnt_n),
    .vcnt(vcnt_n), .sof(sof_n)
  );

  // Drive one clock of stimulus, advance the model, and form expectations.
  task automatic cycle(input logic r, input logic en, input logic c, input logic rs);
    int eh, ev;
    logic hs, vs, hb, vb;
    rst = r; enable = en; ce = c; resync = rs;
    @(posedge clk);
    if (r || !en || rs) begin
      pos = LAST_POS; esof = 1'b0;
    end else if (c) begin
      pos = (pos + 1) % FRAME; esof = (pos == 0);
    end else begin
      esof = 1'b0;
    end
    #1;
    eh = pos % H_TOT;
    ev = pos / H_TOT;
    hb = (eh >= 8);
    vb = (ev >= 4);
    hs = (eh >= 10) && (eh <= 12);
    vs = (ev >= 5) && (ev <= 6);
    exp_w = {4'(eh), 3'(ev), hs, vs, hb, vb, !hb && !vb, esof, !hs, !vs};
  endtask

  task automatic test_reset();
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (act_w !== exp_w) begin
      failures++; $display("FAIL reset_model got=%h exp=%h", act_w, exp_w);
    end
    checks++;
    if ({hcnt, vcnt, hsync, vsync, hblank, vblank, active, sof} !== {4'd15, 3'd7, 6'b001100}) begin
      failures++; $display("FAIL reset_values got=%h", {hcnt, vcnt, hsync, vsync, hblank, vblank, active, sof});
    end
    checks++;
    if ({hsync_n, vsync_n, fid, fid_n, ppl, lpf} !== {4'b1100, 4'd8, 3'd4}) begin
      failures++; $display("FAIL reset_consts got=%h exp=%h", {hsync_n, vsync_n, fid, fid_n, ppl, lpf}, {4'b1100, 4'd8, 3'd4});
    end
  endtask

  task automatic test_free_run();
    int act_cnt = 0, last_sof = -1, sof_cnt = 0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      if (i == 0) begin
        checks++;
        if ({sof, active, hcnt, vcnt} !== {2'b11, 4'd0, 3'd0}) begin
          failures++; $display("FAIL first_sof got=%h exp=%h", {sof, active, hcnt, vcnt}, {2'b11, 7'd0});
        end
      end
      checks++;
      if (act_w !== exp_w) begin
        failures++; $display("FAIL free_run i=%0d got=%h exp=%h", i, act_w, exp_w);
      end
      if (active) act_cnt++;
      if (sof) begin
        sof_cnt++;
        if (last_sof >= 0) begin
          checks++;
          if (i - last_sof !== FRAME) begin
            failures++; $display("FAIL sof_period got=%0d exp=%0d", i - last_sof, FRAME);
          end
        end
        last_sof = i;
      end
    end
    checks++;
    if (act_cnt !== 64 || sof_cnt !== 2) begin
      failures++; $display("FAIL active_count got=%0d/%0d exp=64/2", act_cnt, sof_cnt);
    end
  endtask

  task automatic test_sync_placement();
    int hs_cnt = 0, vs_cnt = 0, vb_cnt = 0;
    logic prev_vs;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    prev_vs = vsync;
    for (int i = 0; i < FRAME; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      checks++;
      if (act_w !== exp_w) begin
        failures++; $display("FAIL sync_vec i=%0d got=%h exp=%h", i, act_w, exp_w);
      end
      if (vsync !== prev_vs) begin
        checks++;
        if (hcnt !== 4'd0) begin
          failures++; $display("FAIL vsync_edge hcnt got=%0d exp=0", hcnt);
        end
      end
      prev_vs = vsync;
      if (hsync) hs_cnt++;
      if (vsync) vs_cnt++;
      if (vblank) vb_cnt++;
    end
    checks++;
    if (hs_cnt !== 24 || vs_cnt !== 32 || vb_cnt !== 64) begin
      failures++; $display("FAIL sync_counts got=%0d/%0d/%0d exp=24/32/64", hs_cnt, vs_cnt, vb_cnt);
    end
  endtask

  task automatic test_throttle();
    int last_sof = -1, nsof = 0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3 * FRAME * 3; i++) begin
      cycle(1'b0, 1'b1, (i % 3) == 0, 1'b0);
      checks++;
      if (act_w !== exp_w) begin
        failures++; $display("FAIL throttle i=%0d got=%h exp=%h", i, act_w, exp_w);
      end
      if (sof) begin
        nsof++;
        if (last_sof >= 0) begin
          checks++;
          if (i - last_sof !== 3 * FRAME) begin
            failures++; $display("FAIL throttle_period got=%0d exp=%0d", i - last_sof, 3 * FRAME);
          end
        end
        last_sof = i;
      end
    end
    checks++;
    if (nsof !== 3) begin
      failures++; $display("FAIL throttle_sof_count got=%0d exp=3", nsof);
    end
  endtask

  task automatic test_polarity();
    int hs_low = 0, vs_low = 0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      if (!hsync_n) begin
        hs_low++;
        checks++;
        if (hcnt_n < 4'd10 || hcnt_n > 4'd12) begin
          failures++; $display("FAIL inv_hsync_pos got=%0d exp=10..12", hcnt_n);
        end
      end
      if (!vsync_n) vs_low++;
    end
    checks++;
    if (hs_low !== 24 || vs_low !== 32) begin
      failures++; $display("FAIL inv_counts got=%0d/%0d exp=24/32", hs_low, vs_low);
    end
  endtask

  task automatic test_resync();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (38) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({hcnt, vcnt} !== {4'd5, 3'd2}) begin
      failures++; $display("FAIL resync_setup got=%0d,%0d exp=5,2", hcnt, vcnt);
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({hcnt, vcnt, hblank, vblank, sof} !== {4'd15, 3'd7, 3'b110}) begin
      failures++; $display("FAIL resync_park got=%h exp=%h", {hcnt, vcnt, hblank, vblank, sof}, {4'd15, 3'd7, 3'b110});
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({sof, hcnt, vcnt} !== {1'b1, 4'd0, 3'd0}) begin
      failures++; $display("FAIL resync_sof got=%h exp=%h", {sof, hcnt, vcnt}, {1'b1, 7'd0});
    end
  endtask

  task automatic test_enable_rst();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (52) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if ({hcnt, vcnt, hsync, vsync, hblank, vblank, active, sof} !== {4'd15, 3'd7, 6'b001100}) begin
        failures++; $display("FAIL disable_hold i=%0d got=%h", i, {hcnt, vcnt, hsync, vsync, hblank, vblank, active, sof});
      end
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({sof, hcnt, vcnt} !== {1'b1, 4'd0, 3'd0}) begin
      failures++; $display("FAIL reenable_sof got=%h exp=%h", {sof, hcnt, vcnt}, {1'b1, 7'd0});
    end
    repeat (20) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({hcnt, vcnt, hblank, vblank, active, sof} !== {4'd15, 3'd7, 4'b1100}) begin
      failures++; $display("FAIL rst_mid got=%h", {hcnt, vcnt, hblank, vblank, active, sof});
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({sof, hcnt, vcnt} !== {1'b1, 4'd0, 3'd0}) begin
      failures++; $display("FAIL rst_sof got=%h exp=%h", {sof, hcnt, vcnt}, {1'b1, 7'd0});
    end
  endtask

  task automatic test_random();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) != 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 149) == 0));
      checks++;
      if (act_w !== exp_w) begin
        failures++; $display("FAIL random i=%0d got=%h exp=%h", i, act_w, exp_w);
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_sync_placement();
    test_throttle();
    test_polarity();
    test_resync();
    test_enable_rst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
